// File: rtl/sram_req_responder.sv
// Responder for the single-port SRAM request interface: queues read/write pulses,
// arbitrates one array access per cycle, and returns read data after RD_LATENCY cycles.
module sram_req_responder #(
   parameter int DATA_WIDTH      = 64,
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int MEM_ADDR_BITS   = 10,
   parameter int Q_DEPTH_BITS    = 3,
   parameter int RD_LATENCY      = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rd_0_req,
   input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
   output logic                       rd_0_ack,
   output logic                       rd_0_vld,
   output logic [DATA_WIDTH-1:0]      rd_0_data,
   input  logic                       wr_0_req,
   input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
   input  logic [DATA_WIDTH-1:0]      wr_0_data,
   output logic                       wr_0_ack,
   output logic                       rd_overflow,
   output logic                       wr_overflow
);
   localparam int QD = 1 << Q_DEPTH_BITS;
   localparam int MD = 1 << MEM_ADDR_BITS;

   typedef enum logic {ARB_WR_PRI, ARB_RD_PRI} arb_t;

   logic [DATA_WIDTH-1:0]    r_mem [MD];

   logic [MEM_ADDR_BITS-1:0] r_wq_addr [QD];
   logic [DATA_WIDTH-1:0]    r_wq_data [QD];
   logic [MEM_ADDR_BITS-1:0] r_rq_addr [QD];
   logic [Q_DEPTH_BITS:0]    r_wq_wp, r_wq_rp, r_rq_wp, r_rq_rp;
   logic                     r_rd_ovf, r_wr_ovf;

   arb_t                     r_arb, w_arb_nxt;
   logic                     w_wr_gnt, w_rd_gnt;

   logic [RD_LATENCY:1]      r_vld_pipe;
   logic [DATA_WIDTH-1:0]    r_dpipe [1:RD_LATENCY];

   logic w_wq_empty, w_wq_full, w_rq_empty, w_rq_full;
   logic w_wq_push, w_rq_push;
   logic [MEM_ADDR_BITS-1:0] w_wq_head_addr, w_rq_head_addr;
   logic w_unused_addr_bits;

   // Only the low address bits index the array; the rest alias.
   assign w_unused_addr_bits = ^{rd_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_BITS],
                                 wr_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_BITS]};

   assign w_wq_empty = (r_wq_wp == r_wq_rp);
   assign w_rq_empty = (r_rq_wp == r_rq_rp);
   assign w_wq_full  = (r_wq_wp[Q_DEPTH_BITS] != r_wq_rp[Q_DEPTH_BITS]) &&
                       (r_wq_wp[Q_DEPTH_BITS-1:0] == r_wq_rp[Q_DEPTH_BITS-1:0]);
   assign w_rq_full  = (r_rq_wp[Q_DEPTH_BITS] != r_rq_rp[Q_DEPTH_BITS]) &&
                       (r_rq_wp[Q_DEPTH_BITS-1:0] == r_rq_rp[Q_DEPTH_BITS-1:0]);

   // A full queue still accepts when its head leaves in the same cycle.
   assign w_wq_push = wr_0_req && (!w_wq_full || w_wr_gnt);
   assign w_rq_push = rd_0_req && (!w_rq_full || w_rd_gnt);

   assign w_wq_head_addr = r_wq_addr[r_wq_rp[Q_DEPTH_BITS-1:0]];
   assign w_rq_head_addr = r_rq_addr[r_rq_rp[Q_DEPTH_BITS-1:0]];

   always_ff @(posedge clk) begin
      if (w_wq_push) begin
         r_wq_addr[r_wq_wp[Q_DEPTH_BITS-1:0]] <= wr_0_addr[MEM_ADDR_BITS-1:0];
         r_wq_data[r_wq_wp[Q_DEPTH_BITS-1:0]] <= wr_0_data;
      end
      if (w_rq_push)
         r_rq_addr[r_rq_wp[Q_DEPTH_BITS-1:0]] <= rd_0_addr[MEM_ADDR_BITS-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wq_wp  <= '0;
         r_wq_rp  <= '0;
         r_rq_wp  <= '0;
         r_rq_rp  <= '0;
         r_rd_ovf <= 1'b0;
         r_wr_ovf <= 1'b0;
      end else begin
         if (w_wq_push) r_wq_wp <= r_wq_wp + 1'b1;
         if (w_rq_push) r_rq_wp <= r_rq_wp + 1'b1;
         if (w_wr_gnt)  r_wq_rp <= r_wq_rp + 1'b1;
         if (w_rd_gnt)  r_rq_rp <= r_rq_rp + 1'b1;
         if (wr_0_req && !w_wq_push) r_wr_ovf <= 1'b1;
         if (rd_0_req && !w_rq_push) r_rd_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_arb <= ARB_WR_PRI;
      else       r_arb <= w_arb_nxt;
   end

   always_comb begin
      w_arb_nxt = r_arb;
      if (!w_wq_empty && !w_rq_empty)
         w_arb_nxt = (r_arb == ARB_WR_PRI) ? ARB_RD_PRI : ARB_WR_PRI;
   end

   always_comb begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
      if (!reset) begin
         case (r_arb)
            ARB_WR_PRI: begin
               w_wr_gnt = !w_wq_empty;
               w_rd_gnt = !w_rq_empty && w_wq_empty;
            end
            default: begin
               w_rd_gnt = !w_rq_empty;
               w_wr_gnt = !w_wq_empty && w_rq_empty;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_gnt) r_mem[w_wq_head_addr] <= r_wq_data[r_wq_rp[Q_DEPTH_BITS-1:0]];
   end

   // Each data stage loads only behind a valid, so the last stage holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_pipe <= '0;
         for (int k = 1; k <= RD_LATENCY; k++) r_dpipe[k] <= '0;
      end else begin
         r_vld_pipe[1] <= w_rd_gnt;
         if (w_rd_gnt) r_dpipe[1] <= r_mem[w_rq_head_addr];
         for (int k = 2; k <= RD_LATENCY; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            if (r_vld_pipe[k-1]) r_dpipe[k] <= r_dpipe[k-1];
         end
      end
   end

   assign wr_0_ack    = w_wr_gnt;
   assign rd_0_ack    = w_rd_gnt;
   assign rd_0_vld    = r_vld_pipe[RD_LATENCY];
   assign rd_0_data   = r_dpipe[RD_LATENCY];
   assign rd_overflow = r_rd_ovf;
   assign wr_overflow = r_wr_ovf;
endmodule
